// File: rtl/blink_pattern_gen.sv
// LED pattern generator: a clock-enable divider advances a WIDTH-bit pattern
// every DIV enabled clocks in up, down, bounce or Johnson mode.
module blink_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    M_UP      = 2'b00,
    M_DOWN    = 2'b01,
    M_BOUNCE  = 2'b10,
    M_JOHNSON = 2'b11
  } mode_t;

  mode_t           mode_in;
  mode_t           mode_q;
  mode_t           mode_q_nxt;
  logic [CW-1:0]   div_cnt;
  logic [CW-1:0]   div_cnt_nxt;
  logic            dir;
  logic            dir_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] step_q;
  logic            step_dir;
  logic            tick_nxt;

  assign mode_in = mode_t'(mode);

  function automatic logic [WIDTH-1:0] seed(input mode_t m);
    case (m)
      M_DOWN:   seed = '1;
      M_BOUNCE: seed = WIDTH'(1);
      default:  seed = '0;
    endcase
  endfunction

  // Pattern value and bounce direction that a step would produce.
  always_comb begin
    step_q   = q;
    step_dir = dir;
    case (mode_q)
      M_UP:   step_q = q + WIDTH'(1);
      M_DOWN: step_q = q - WIDTH'(1);
      M_BOUNCE: begin
        if (!dir) begin
          if (q[WIDTH-1]) begin
            step_q   = q >> 1;
            step_dir = 1'b1;
          end else begin
            step_q   = q << 1;
            step_dir = step_q[WIDTH-1];
          end
        end else begin
          step_q   = q >> 1;
          step_dir = !step_q[0];
        end
      end
      default: step_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
    endcase
  end

  // Mode change outranks a step; reset is applied in the register process.
  always_comb begin
    mode_q_nxt  = mode_q;
    q_nxt       = q;
    div_cnt_nxt = div_cnt;
    dir_nxt     = dir;
    tick_nxt    = 1'b0;
    if (mode_in != mode_q) begin
      mode_q_nxt  = mode_in;
      q_nxt       = seed(mode_in);
      div_cnt_nxt = '0;
      dir_nxt     = 1'b0;
    end else if (en) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt_nxt = '0;
        q_nxt       = step_q;
        dir_nxt     = step_dir;
        tick_nxt    = 1'b1;
      end else begin
        div_cnt_nxt = div_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= mode_in;
      q       <= seed(mode_in);
      div_cnt <= '0;
      dir     <= 1'b0;
      tick    <= 1'b0;
    end else begin
      mode_q  <= mode_q_nxt;
      q       <= q_nxt;
      div_cnt <= div_cnt_nxt;
      dir     <= dir_nxt;
      tick    <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_blink_pattern_gen.sv
// Scoreboard bench for blink_pattern_gen at WIDTH=4, DIV=4: stimulus queues the
// expected q/tick for each edge, a negedge monitor pops and compares.
module tb_blink_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] q;
  logic       tick;

  blink_pattern_gen #(.WIDTH(4), .DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .q    (q),
    .tick (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic       t;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;
  logic [3:0] cur;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      nvec++;
      if (q !== e.q || tick !== e.t) begin
        nmis++;
        $display("FAIL %s vec%0d: q=%b tick=%b, want q=%b tick=%b",
                 e.tag, nvec, q, tick, e.q, e.t);
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                     input logic [3:0] eq, input logic et, input string tag);
    exp_t x;
    rst  = r;
    en   = e;
    mode = m;
    @(posedge clk);
    #1;
    x.q = eq; x.t = et; x.tag = tag;
    sb.push_back(x);
  endtask

  // Three counting edges holding `cur`, then a step edge showing `nq` with tick.
  task automatic period(input logic [1:0] m, input logic [3:0] nq, input string tag);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, m, cur, 1'b0, tag);
    cur = nq;
    cyc(1'b0, 1'b1, m, cur, 1'b1, tag);
  endtask

  logic [3:0] bounce_tbl [7]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [3:0] johnson_tbl [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

  initial begin
    @(negedge clk);

    // Up: seed 0, 16 steps wrapping back to 0.
    cur = 4'h0;
    cyc(1'b1, 1'b1, 2'b00, 4'h0, 1'b0, "up_reset");
    for (int k = 1; k <= 16; k++) period(2'b00, cur + 4'h1, "up_step");

    // Down: seed all ones, 16 steps through 0 back to all ones.
    cur = 4'hF;
    cyc(1'b1, 1'b1, 2'b01, 4'hF, 1'b0, "down_reset");
    for (int k = 1; k <= 16; k++) period(2'b01, cur - 4'h1, "down_step");

    // Bounce ping-pong.
    cur = 4'b0001;
    cyc(1'b1, 1'b1, 2'b10, 4'b0001, 1'b0, "bounce_reset");
    for (int k = 0; k < 7; k++) period(2'b10, bounce_tbl[k], "bounce_step");

    // Johnson ring, full period of 8.
    cur = 4'b0000;
    cyc(1'b1, 1'b1, 2'b11, 4'b0000, 1'b0, "johnson_reset");
    for (int k = 0; k < 8; k++) period(2'b11, johnson_tbl[k], "johnson_step");

    // Enable gap at div_cnt=2: frozen 5 cycles, step 9 clocks after the previous one.
    cur = 4'h0;
    cyc(1'b1, 1'b1, 2'b00, 4'h0, 1'b0, "gap_reset");
    period(2'b00, 4'h1, "gap_first");
    cyc(1'b0, 1'b1, 2'b00, 4'h1, 1'b0, "gap_cnt1");
    cyc(1'b0, 1'b1, 2'b00, 4'h1, 1'b0, "gap_cnt2");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 2'b00, 4'h1, 1'b0, "gap_frozen");
    cyc(1'b0, 1'b1, 2'b00, 4'h1, 1'b0, "gap_cnt3");
    cyc(1'b0, 1'b1, 2'b00, 4'h2, 1'b1, "gap_step");

    // Mode change while disabled still loads the seed.
    cyc(1'b0, 1'b0, 2'b11, 4'h0, 1'b0, "modechg_en0");
    cyc(1'b0, 1'b0, 2'b11, 4'h0, 1'b0, "modechg_en0_hold");

    // Down -> bounce on the would-be step edge: seed loaded, no tick.
    cyc(1'b1, 1'b1, 2'b01, 4'hF, 1'b0, "sw_reset");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b01, 4'hF, 1'b0, "sw_count");
    cyc(1'b0, 1'b1, 2'b10, 4'b0001, 1'b0, "sw_modechg");
    cur = 4'b0001;
    period(2'b10, 4'b0010, "sw_next_step");

    // Reset mid-period in bounce while moving right: dir and divider restart.
    period(2'b10, 4'b0100, "rst_b1");
    period(2'b10, 4'b1000, "rst_b2");
    period(2'b10, 4'b0100, "rst_b3");
    cyc(1'b0, 1'b1, 2'b10, 4'b0100, 1'b0, "rst_cnt1");
    cyc(1'b0, 1'b1, 2'b10, 4'b0100, 1'b0, "rst_cnt2");
    cyc(1'b1, 1'b1, 2'b10, 4'b0001, 1'b0, "rst_mid");
    cur = 4'b0001;
    period(2'b10, 4'b0010, "rst_after");

    // Reset on the same edge as a step wins.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b10, 4'b0010, 1'b0, "rst_step_cnt");
    cyc(1'b1, 1'b1, 2'b10, 4'b0001, 1'b0, "rst_vs_step");

    en = 1'b0;
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
